// File: rtl/solitaire_move_ctrl.sv
// solitaire_move_ctrl: move-command sequencer in front of the peg-solitaire board.
// Takes move commands over a valid/ready handshake, presents each one to the board
// for exactly one cycle and otherwise parks the board on a move that can never be
// legal. Accept/reject is inferred from the drop in the board's peg count. The
// block owns the board reset and tracks the win/lose outcome of a game.
//
// Build option: define SOLITAIRE_REJECT_STATS_EN to add the reject_count output,
// a saturating count of rejected moves since the last board reset.
module solitaire_move_ctrl #(
  parameter logic [2:0]  PARK_X           = 3'd0,
  parameter logic [2:0]  PARK_Y           = 3'd0,
  parameter logic [1:0]  PARK_DIR         = 2'b00,
  parameter int unsigned BOARD_RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_x,
  input  logic [2:0] cmd_y,
  input  logic [1:0] cmd_dir,
  output logic       board_rst_n,
  output logic [2:0] board_piece_x,
  output logic [2:0] board_piece_y,
  output logic [1:0] board_direction,
  input  logic [5:0] board_piece_count,
  input  logic       board_game_over,
  output logic       rsp_valid,
  output logic       rsp_ok,
  output logic [5:0] move_count,
  output logic       won,
  output logic       lost
`ifdef SOLITAIRE_REJECT_STATS_EN
  ,
  output logic [5:0] reject_count
`endif
);

  // Down-counter wide enough to hold BOARD_RST_CYCLES-1.
  localparam int unsigned CntW = (BOARD_RST_CYCLES > 1) ? $clog2(BOARD_RST_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(BOARD_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StBrst,
    StIdle,
    StIssue,
    StCheck,
    StOver
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] rst_cnt_q;
  logic [5:0]      snap_q;     // peg count captured at the handshake
  logic            check_ok;

  // A performed move removes exactly one peg from the board.
  assign check_ok = (board_piece_count == (snap_q - 6'd1));

  // Commands are only taken while idle, and never in a cycle that restarts the game.
  assign cmd_ready = (state_q == StIdle) && !new_game;

  // Sequencer FSM; every board-facing and response output is registered here.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      // A new game behaves like reset: any in-flight move is dropped silently.
      state_q         <= StBrst;
      rst_cnt_q       <= CntInit;
      snap_q          <= 6'd0;
      board_rst_n     <= 1'b0;
      board_piece_x   <= PARK_X;
      board_piece_y   <= PARK_Y;
      board_direction <= PARK_DIR;
      rsp_valid       <= 1'b0;
      rsp_ok          <= 1'b0;
      move_count      <= 6'd0;
      won             <= 1'b0;
      lost            <= 1'b0;
`ifdef SOLITAIRE_REJECT_STATS_EN
      reject_count    <= 6'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StBrst: begin
          if (rst_cnt_q == '0) begin
            state_q     <= StIdle;
            board_rst_n <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - CntW'(1);
          end
        end

        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            // Out-of-range coordinates are passed through; the board rejects them.
            board_piece_x   <= cmd_x;
            board_piece_y   <= cmd_y;
            board_direction <= cmd_dir;
            snap_q          <= board_piece_count;
            state_q         <= StIssue;
          end
        end

        StIssue: begin
          // The board applies the move at this edge; park it again straight away.
          board_piece_x   <= PARK_X;
          board_piece_y   <= PARK_Y;
          board_direction <= PARK_DIR;
          state_q         <= StCheck;
        end

        StCheck: begin
          rsp_valid  <= 1'b1;
          rsp_ok     <= check_ok;
          move_count <= move_count + {5'd0, check_ok};
`ifdef SOLITAIRE_REJECT_STATS_EN
          if (!check_ok && (reject_count != 6'h3f)) begin
            reject_count <= reject_count + 6'd1;
          end
`endif
          if (board_game_over) begin
            state_q <= StOver;
            won     <= (board_piece_count == 6'd1);
            lost    <= (board_piece_count != 6'd1);
          end else begin
            state_q <= StIdle;
          end
        end

        StOver: begin
          // Terminal until new_game.
          state_q <= StOver;
        end

        default: begin
          state_q     <= StBrst;
          rst_cnt_q   <= CntInit;
          board_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// Bench for solitaire_move_ctrl: a behavioural peg-solitaire board stub drives the
// DUT's board side, a transaction-level model predicts every output per cycle, and
// directed moves carry hand-computed literal expectations.
module tb_solitaire_move_ctrl;

  localparam int BRC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_game = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_x = 3'd0;
  logic [2:0] cmd_y = 3'd0;
  logic [1:0] cmd_dir = 2'd0;
  logic       cmd_ready;
  logic       board_rst_n;
  logic [2:0] board_piece_x;
  logic [2:0] board_piece_y;
  logic [1:0] board_direction;
  logic [5:0] bpc;
  logic       bgo;
  logic       rsp_valid;
  logic       rsp_ok;
  logic [5:0] move_count;
  logic       won;
  logic       lost;
`ifdef SOLITAIRE_REJECT_STATS_EN
  logic [5:0] reject_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  solitaire_move_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .new_game          (new_game),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_x             (cmd_x),
    .cmd_y             (cmd_y),
    .cmd_dir           (cmd_dir),
    .board_rst_n       (board_rst_n),
    .board_piece_x     (board_piece_x),
    .board_piece_y     (board_piece_y),
    .board_direction   (board_direction),
    .board_piece_count (bpc),
    .board_game_over   (bgo),
    .rsp_valid         (rsp_valid),
    .rsp_ok            (rsp_ok),
    .move_count        (move_count),
    .won               (won),
    .lost              (lost)
`ifdef SOLITAIRE_REJECT_STATS_EN
    ,
    .reject_count      (reject_count)
`endif
  );

  // ---------------- board rules ----------------
  function automatic bit on_board(int x, int y);
    return (x >= 0) && (x <= 6) && (y >= 0) && (y <= 6) &&
           (((x >= 2) && (x <= 4)) || ((y >= 2) && (y <= 4)));
  endfunction

  function automatic bit peg(logic [48:0] b, int x, int y);
    int i;
    i = y * 7 + x;
    return b[i[5:0]];
  endfunction

  function automatic logic [48:0] set_peg(logic [48:0] b, int x, int y, logic v);
    int i;
    logic [48:0] r;
    i = y * 7 + x;
    r = b;
    r[i[5:0]] = v;
    return r;
  endfunction

  function automatic logic [48:0] full_board();
    logic [48:0] r;
    r = '0;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++)
        if (on_board(x, y) && !((x == 3) && (y == 3))) r = set_peg(r, x, y, 1'b1);
    return r;
  endfunction

  // LEFT/RIGHT move along x, UP/DOWN along y (UP toward row 0).
  function automatic int ddx(logic [1:0] d);
    if (d == 2'b00) return -1;
    if (d == 2'b01) return 1;
    return 0;
  endfunction

  function automatic int ddy(logic [1:0] d);
    if (d == 2'b10) return -1;
    if (d == 2'b11) return 1;
    return 0;
  endfunction

  function automatic bit legal(logic [48:0] b, logic [2:0] x, logic [2:0] y, logic [1:0] d);
    int xi, yi, dx, dy;
    xi = int'(x);
    yi = int'(y);
    dx = ddx(d);
    dy = ddy(d);
    if (!on_board(xi, yi) || !on_board(xi + dx, yi + dy) || !on_board(xi + 2 * dx, yi + 2 * dy))
      return 1'b0;
    return peg(b, xi, yi) && peg(b, xi + dx, yi + dy) && !peg(b, xi + 2 * dx, yi + 2 * dy);
  endfunction

  function automatic logic [48:0] apply_move(logic [48:0] b, logic [2:0] x, logic [2:0] y,
                                             logic [1:0] d);
    logic [48:0] r;
    int xi, yi, dx, dy;
    xi = int'(x);
    yi = int'(y);
    dx = ddx(d);
    dy = ddy(d);
    r = set_peg(b, xi, yi, 1'b0);
    r = set_peg(r, xi + dx, yi + dy, 1'b0);
    r = set_peg(r, xi + 2 * dx, yi + 2 * dy, 1'b1);
    return r;
  endfunction

  // ---------------- board stub + model state ----------------
  logic [48:0] board;
  int          nmoves = 0;
  bit          force_en = 1'b0;   // stub reports force_base - nmoves as piece count
  int          force_base = 0;
  bit          force_go = 1'b0;   // stub reports game over once a move has landed

  assign bpc = force_en ? 6'(force_base - nmoves) : 6'($countones(board));
  assign bgo = force_go && (nmoves >= 1);

  int          cyc = 0;
  bit          live = 1'b0;
  int          brst_until = 0;
  int          idle_from = 0;
  int          issue_at = -100;
  int          resp_at = -100;
  int          mc = 0;
  int          rej = 0;
  bit          over_e = 1'b0;
  bit          won_e = 1'b0;
  bit          lost_e = 1'b0;
  bit          e_ok = 1'b0;
  logic [2:0]  e_x = 3'd0;
  logic [2:0]  e_y = 3'd0;
  logic [1:0]  e_d = 2'd0;
  logic        exp_ready;

  assign exp_ready = live && (cyc >= idle_from) && !over_e && !new_game;

  // Model timeline: a restart blocks commands for BRC cycles; a command taken at
  // edge e is on the board in cycle e, answered in cycle e+2.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || new_game) begin
      if (rst) live <= 1'b1;
      brst_until <= cyc + 1 + BRC;
      idle_from  <= cyc + 1 + BRC;
      issue_at   <= -100;
      resp_at    <= -100;
      mc         <= 0;
      rej        <= 0;
      over_e     <= 1'b0;
      won_e      <= 1'b0;
      lost_e     <= 1'b0;
    end else begin
      if (cyc + 1 == resp_at) begin
        mc <= mc + (e_ok ? 1 : 0);
        if (!e_ok && (rej < 63)) rej <= rej + 1;
        if (bgo) begin
          over_e <= 1'b1;
          won_e  <= (bpc == 6'd1);
          lost_e <= (bpc != 6'd1);
        end
      end
      if (cmd_valid && exp_ready) begin
        issue_at  <= cyc + 1;
        resp_at   <= cyc + 3;
        idle_from <= cyc + 3;
        e_x       <= cmd_x;
        e_y       <= cmd_y;
        e_d       <= cmd_dir;
        e_ok      <= legal(board, cmd_x, cmd_y, cmd_dir);
      end
    end
    if (live) begin
      if (!board_rst_n) begin
        board  <= full_board();
        nmoves <= 0;
      end else if (legal(board, board_piece_x, board_piece_y, board_direction)) begin
        board  <= apply_move(board, board_piece_x, board_piece_y, board_direction);
        nmoves <= nmoves + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    bit on_issue;
    if (!live) return;
    on_issue = (cyc == issue_at);
    check("cmd_ready", 8'(cmd_ready), 8'(exp_ready));
    check("board_rst_n", 8'(board_rst_n), 8'(cyc >= brst_until));
    check("board_piece_x", 8'(board_piece_x), on_issue ? 8'(e_x) : 8'd0);
    check("board_piece_y", 8'(board_piece_y), on_issue ? 8'(e_y) : 8'd0);
    check("board_direction", 8'(board_direction), on_issue ? 8'(e_d) : 8'd0);
    check("rsp_valid", 8'(rsp_valid), 8'(cyc == resp_at));
    if (cyc == resp_at) check("rsp_ok", 8'(rsp_ok), 8'(e_ok));
    check("move_count", 8'(move_count), 8'(mc));
    check("won", 8'(won), 8'(won_e));
    check("lost", 8'(lost), 8'(lost_e));
`ifdef SOLITAIRE_REJECT_STATS_EN
    check("reject_count", 8'(reject_count), 8'(rej));
`endif
  endtask

  // Compare the current cycle on the falling edge, then step to just past the next rise.
  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle the command is on the board.
  task automatic issue_cmd(input logic [2:0] x, input logic [2:0] y, input logic [1:0] d);
    bit hs;
    hs = 1'b0;
    cmd_x = x;
    cmd_y = y;
    cmd_dir = d;
    cmd_valid = 1'b1;
    for (int i = 0; (i < 20) && !hs; i++) begin
      hs = exp_ready;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL handshake: got no ready in 20 cycles, expected ready (t=%0t)", $time);
    end
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    repeat (BRC) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: board held in reset for two cycles, then ready with a clean count.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_brst_n_c1", 8'(board_rst_n), 8'd0);
    check("rst_ready_c1", 8'(cmd_ready), 8'd0);
    tick();
    check("rst_brst_n_c2", 8'(board_rst_n), 8'd0);
    tick();
    check("rst_brst_n_rel", 8'(board_rst_n), 8'd1);
    check("rst_ready", 8'(cmd_ready), 8'd1);
    check("rst_move_count", 8'(move_count), 8'd0);
    check("fresh_count", 8'(bpc), 8'd32);

    // Legal first move (5,3,LEFT) into the empty centre.
    issue_cmd(3'd5, 3'd3, 2'b00);
    check("m1_issue_x", 8'(board_piece_x), 8'd5);
    check("m1_issue_y", 8'(board_piece_y), 8'd3);
    check("m1_issue_dir", 8'(board_direction), 8'd0);
    tick();
    check("m1_parked_x", 8'(board_piece_x), 8'd0);
    check("m1_count", 8'(bpc), 8'd31);
    tick();
    check("m1_rsp_valid", 8'(rsp_valid), 8'd1);
    check("m1_rsp_ok", 8'(rsp_ok), 8'd1);
    check("m1_move_count", 8'(move_count), 8'd1);
    check("m1_ready_again", 8'(cmd_ready), 8'd1);

    // Illegal move on a fresh board: centre is empty.
    do_new_game();
    check("ng_count", 8'(bpc), 8'd32);
    check("ng_move_count", 8'(move_count), 8'd0);
    issue_cmd(3'd3, 3'd3, 2'b00);
    check("bad_issue_x", 8'(board_piece_x), 8'd3);
    tick();
    tick();
    check("bad_rsp_valid", 8'(rsp_valid), 8'd1);
    check("bad_rsp_ok", 8'(rsp_ok), 8'd0);
    check("bad_move_count", 8'(move_count), 8'd0);
    check("bad_count", 8'(bpc), 8'd32);

    // Back-to-back legal moves at full throughput.
    issue_cmd(3'd5, 3'd3, 2'b00);
    tick();
    tick();
    issue_cmd(3'd4, 3'd1, 2'b11);
    tick();
    tick();
    check("b2b_move_count", 8'(move_count), 8'd2);
    check("b2b_count", 8'(bpc), 8'd30);
    issue_cmd(3'd3, 3'd5, 2'b10);
    tick();
    tick();

    // new_game during the issue cycle: response dropped, board restarted.
    issue_cmd(3'd2, 3'd3, 2'b01);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("abort_rsp_valid_1", 8'(rsp_valid), 8'd0);
    check("abort_brst_n", 8'(board_rst_n), 8'd0);
    check("abort_move_count", 8'(move_count), 8'd0);
    check("abort_parked", 8'(board_piece_x), 8'd0);
    tick();
    check("abort_rsp_valid_2", 8'(rsp_valid), 8'd0);
    tick();
    check("abort_count", 8'(bpc), 8'd32);
    check("abort_ready", 8'(cmd_ready), 8'd1);

    // Winning finish: stub reports 2 pegs, then 1 with game over.
    force_base = 2;
    force_en = 1'b1;
    force_go = 1'b1;
    issue_cmd(3'd5, 3'd3, 2'b00);
    tick();
    tick();
    check("win_rsp_ok", 8'(rsp_ok), 8'd1);
    check("win_won", 8'(won), 8'd1);
    check("win_lost", 8'(lost), 8'd0);
    check("win_ready", 8'(cmd_ready), 8'd0);
    cmd_valid = 1'b1;
    repeat (4) tick();
    cmd_valid = 1'b0;
    check("over_hold_ready", 8'(cmd_ready), 8'd0);
    check("over_hold_won", 8'(won), 8'd1);
    force_en = 1'b0;
    force_go = 1'b0;
    do_new_game();
    check("post_win_cleared", 8'(won), 8'd0);

    // Losing finish: five pegs left at game over.
    force_base = 6;
    force_en = 1'b1;
    force_go = 1'b1;
    issue_cmd(3'd5, 3'd3, 2'b00);
    tick();
    tick();
    check("lose_lost", 8'(lost), 8'd1);
    check("lose_won", 8'(won), 8'd0);
    force_en = 1'b0;
    force_go = 1'b0;
    do_new_game();

    // Three rejected commands, including an out-of-range column.
    issue_cmd(3'd3, 3'd3, 2'b00);
    tick();
    tick();
    issue_cmd(3'd7, 3'd0, 2'b01);
    check("oor_issue_x", 8'(board_piece_x), 8'd7);
    tick();
    tick();
    check("oor_rsp_ok", 8'(rsp_ok), 8'd0);
    issue_cmd(3'd0, 3'd0, 2'b00);
    tick();
    tick();
`ifdef SOLITAIRE_REJECT_STATS_EN
    check("reject_count_3", 8'(reject_count), 8'd3);
`endif
    check("rej_move_count", 8'(move_count), 8'd0);

    // Reset in the check cycle: no response for the in-flight move.
    issue_cmd(3'd5, 3'd3, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_rsp_valid", 8'(rsp_valid), 8'd0);
    check("rst_mid_move_count", 8'(move_count), 8'd0);
    repeat (BRC + 2) tick();
    check("rst_mid_count", 8'(bpc), 8'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
